// File: rtl/k423_pkg.sv
// Shared types and sizing for the k423 instruction queue.
//   CORE_ADDR_W   : pc / predicted-target width
//   CORE_INST_W   : instruction width
//   IQ_DEPTH_DFLT : default queue depth
//   iq_entry_t    : one buffered fetch record {pc, inst, prediction}
package k423_pkg;

   localparam int unsigned CORE_ADDR_W   = 32;
   localparam int unsigned CORE_INST_W   = 32;
   localparam int unsigned IQ_DEPTH_DFLT = 4;

   typedef struct packed {
      logic [CORE_ADDR_W-1:0] pc;
      logic [CORE_INST_W-1:0] inst;
      logic                   prd_tkn;
      logic [CORE_ADDR_W-1:0] prd_pc;
      logic [1:0]             prd_sat_cnt;
   } iq_entry_t;

endpackage

// File: rtl/k423_iq_ptr_ctrl.sv
// Pointer and occupancy control for the instruction queue.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   flush_i        : clear pointers and count (priority over push/pop)
//   push_i, pop_i  : qualified write / read strobes
//   wr_ptr_o       : next slot to write
//   rd_ptr_o       : head slot
//   cnt_o          : number of valid entries (0..DEPTH)
//   full_c         : cnt == DEPTH (combinational from registered count)
//   empty_c        : cnt == 0     (combinational from registered count)
module k423_iq_ptr_ctrl
   import k423_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH_DFLT,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   output logic [PTR_W-1:0] wr_ptr_o,
   output logic [PTR_W-1:0] rd_ptr_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             full_c,
   output logic             empty_c
);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_o <= '0;
         rd_ptr_o <= '0;
         cnt_o    <= '0;
      end else if (flush_i) begin
         wr_ptr_o <= '0;
         rd_ptr_o <= '0;
         cnt_o    <= '0;
      end else begin
         if (push_i) wr_ptr_o <= wr_ptr_o + PTR_W'(1);
         if (pop_i)  rd_ptr_o <= rd_ptr_o + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   cnt_o <= cnt_o + CNT_W'(1);
            2'b01:   cnt_o <= cnt_o - CNT_W'(1);
            default: cnt_o <= cnt_o;
         endcase
      end
   end

   assign full_c  = (cnt_o == CNT_W'(DEPTH));
   assign empty_c = (cnt_o == '0);

endmodule

// File: rtl/k423_if_inst_queue.sv
// Instruction queue between IF and ID: buffers {pc, inst, BPU prediction}
// so an ID/EX stall does not stall fetch; drains in order via valid/ready.
// Optional feature macro: K423_IQ_BYPASS_EN (empty-queue 0-cycle bypass).
// Ports:
//   clk_i, rst_n_i        : clock, async active-low reset
//   flush_i               : drop all entries and any same-cycle push
//   if_stage_vld_i        : IF offers an entry
//   iq_rdy_o              : queue can accept an entry (not full)
//   if_pc_i .. if_bpu_prd_sat_cnt_i : fetched entry fields
//   iq_vld_o              : head entry valid toward ID
//   id_stage_rdy_i        : ID accepts the head entry
//   iq_pc_o .. iq_bpu_prd_sat_cnt_o : head entry fields
module k423_if_inst_queue
   import k423_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH_DFLT
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   flush_i,
   input  logic                   if_stage_vld_i,
   output logic                   iq_rdy_o,
   input  logic [CORE_ADDR_W-1:0] if_pc_i,
   input  logic [CORE_INST_W-1:0] if_inst_i,
   input  logic                   if_bpu_prd_tkn_i,
   input  logic [CORE_ADDR_W-1:0] if_bpu_prd_pc_i,
   input  logic [1:0]             if_bpu_prd_sat_cnt_i,
   output logic                   iq_vld_o,
   input  logic                   id_stage_rdy_i,
   output logic [CORE_ADDR_W-1:0] iq_pc_o,
   output logic [CORE_INST_W-1:0] iq_inst_o,
   output logic                   iq_bpu_prd_tkn_o,
   output logic [CORE_ADDR_W-1:0] iq_bpu_prd_pc_o,
   output logic [1:0]             iq_bpu_prd_sat_cnt_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   iq_entry_t        mem [DEPTH];
   iq_entry_t        in_ent_c;
   iq_entry_t        head_c;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             full_c;
   logic             empty_c;
   logic             bypass_c;
   logic             push_c;
   logic             pop_c;
   logic             wr_en_c;
   logic             rd_en_c;

   assign in_ent_c = '{pc:          if_pc_i,
                       inst:        if_inst_i,
                       prd_tkn:     if_bpu_prd_tkn_i,
                       prd_pc:      if_bpu_prd_pc_i,
                       prd_sat_cnt: if_bpu_prd_sat_cnt_i};

`ifdef K423_IQ_BYPASS_EN
   // Empty queue with a live fetch: present the fetch to ID in the same cycle.
   assign bypass_c = empty_c & if_stage_vld_i & ~flush_i;
`else
   assign bypass_c = 1'b0;
`endif

   assign iq_rdy_o = ~full_c;
   assign iq_vld_o = (~empty_c & ~flush_i) | bypass_c;
   assign push_c   = if_stage_vld_i & iq_rdy_o & ~flush_i;
   assign pop_c    = iq_vld_o & id_stage_rdy_i;

   // A bypassed entry consumed by ID is never stored; one that is not
   // consumed is written like a normal push.
   assign wr_en_c  = push_c & ~(bypass_c & id_stage_rdy_i);
   assign rd_en_c  = pop_c & ~bypass_c;

   k423_iq_ptr_ctrl #(
      .DEPTH (DEPTH)
   ) u_ptr_ctrl (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .flush_i  (flush_i),
      .push_i   (wr_en_c),
      .pop_i    (rd_en_c),
      .wr_ptr_o (wr_ptr),
      .rd_ptr_o (rd_ptr),
      .cnt_o    (cnt),
      .full_c   (full_c),
      .empty_c  (empty_c)
   );

   // Entry storage; flush leaves contents in place, reset clears them.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en_c) begin
         mem[wr_ptr] <= in_ent_c;
      end
   end

   // Head selection: storage slot, or the incoming fetch when bypassing.
   always_comb begin
      head_c = mem[rd_ptr];
      if (bypass_c) head_c = in_ent_c;
   end

   assign iq_pc_o              = head_c.pc;
   assign iq_inst_o            = head_c.inst;
   assign iq_bpu_prd_tkn_o     = head_c.prd_tkn;
   assign iq_bpu_prd_pc_o      = head_c.prd_pc;
   assign iq_bpu_prd_sat_cnt_o = head_c.prd_sat_cnt;

endmodule
